// File: rtl/simmem_pkg.sv
// Shared types and defaults for the simulated-memory write-response delay stage.
package simmem_pkg;

    localparam int unsigned WRspDelaySlots = 8;
    localparam int unsigned WDelayW        = 8;
    localparam int unsigned WDelayTotCapa  = 16;
    localparam int unsigned WDelayIidW     = $clog2(WDelayTotCapa);

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Count   = 2'd1,
        Release = 2'd2
    } wdelay_phase_e;

    typedef struct packed {
        logic                  valid;
        logic [WDelayIidW-1:0] iid;
        logic [WDelayW-1:0]    counter;
        wdelay_phase_e         phase;
    } wdelay_slot_t;

endpackage

// File: rtl/simmem_delay_slot.sv
// One tracked write request: loads a latency, counts it down, then waits for the bank's release ack.
module simmem_delay_slot
    import simmem_pkg::*;
#(
    parameter int unsigned TotCapa = WDelayTotCapa,
    parameter int unsigned DelayW  = WDelayW,
    parameter int unsigned IidW    = $clog2(TotCapa)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [IidW-1:0]    iid_i,
    input  logic [DelayW-1:0]  delay_i,
    input  logic [TotCapa-1:0] ack_i,
    output logic               valid_o,
    output logic [IidW-1:0]    iid_o,
    output logic               release_o,
    output logic               retire_o
);

    wdelay_phase_e     phase_q, phase_d;
    logic [IidW-1:0]   iid_q, iid_d;
    logic [DelayW-1:0] cnt_q, cnt_d;

    assign valid_o   = (phase_q != Idle);
    assign iid_o     = iid_q;
    assign release_o = (phase_q == Release);
    assign retire_o  = release_o && ack_i[iid_q];

    always_comb begin
        phase_d = phase_q;
        iid_d   = iid_q;
        cnt_d   = cnt_q;
        unique case (phase_q)
            Idle: begin
                if (load_i) begin
                    iid_d   = iid_i;
                    cnt_d   = delay_i;
                    phase_d = (delay_i == '0) ? Release : Count;
                end
            end
            Count: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == DelayW'(1)) begin
                    phase_d = Release;
                end
            end
            Release: begin
                if (retire_o) begin
                    phase_d = Idle;
                end
            end
            default: phase_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= Idle;
            iid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            iid_q   <= iid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/simmem_wresp_delay_tracker.sv
// Write-response delay stage: holds each write for a simulated latency before enabling its release.
// Optional SIMMEM_DELAY_STATS_EN adds retired-entry and occupancy high-water counters.
module simmem_wresp_delay_tracker
    import simmem_pkg::*;
#(
    parameter int unsigned TotCapa    = WDelayTotCapa,
    parameter int unsigned NumSlots   = WRspDelaySlots,
    parameter int unsigned DelayW     = WDelayW,
    parameter int unsigned FixedDelay = 10,
    parameter int unsigned BeatCost   = 1,
    localparam int unsigned IidW      = $clog2(TotCapa),
    localparam int unsigned OccW      = $clog2(NumSlots + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wreq_valid_i,
    output logic               wreq_ready_o,
    input  logic [IidW-1:0]    wreq_iid_i,
    input  logic [7:0]         wreq_burst_len_i,
    output logic [TotCapa-1:0] release_en_o,
    input  logic [TotCapa-1:0] released_addr_onehot_i,
    output logic               delay_calc_ready_o,
    output logic [OccW-1:0]    occupancy_o
`ifdef SIMMEM_DELAY_STATS_EN
    ,
    output logic [31:0]        stat_releases_o,
    output logic [OccW-1:0]    stat_max_occ_o
`endif
);

    localparam int unsigned CalcW = DelayW + 8;
    localparam logic [CalcW-1:0] DelayMax = {{8{1'b0}}, {DelayW{1'b1}}};

    logic [NumSlots-1:0] slot_valid, slot_release, slot_retire, alloc_oh, slot_load;
    logic [IidW-1:0]     slot_iid [NumSlots];
    logic                accept, iid_busy;
    logic [CalcW-1:0]    delay_full;
    logic [DelayW-1:0]   delay_load;
    logic [OccW-1:0]     occ_q, occ_d, num_retire;

    always_comb begin
        delay_full = CalcW'(FixedDelay) + CalcW'(wreq_burst_len_i) * CalcW'(BeatCost);
        delay_load = (delay_full > DelayMax) ? '1 : delay_full[DelayW-1:0];
    end

    // Lowest-index free slot, judged on registered state so a slot retiring now is not reused yet.
    always_comb begin
        alloc_oh = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (!slot_valid[i] && (alloc_oh == '0)) begin
                alloc_oh[i] = 1'b1;
            end
        end
    end

    assign wreq_ready_o       = ~&slot_valid;
    assign delay_calc_ready_o = wreq_ready_o;
    assign accept             = wreq_valid_i && wreq_ready_o;
    assign slot_load          = alloc_oh & {NumSlots{accept}};

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        simmem_delay_slot #(
            .TotCapa (TotCapa),
            .DelayW  (DelayW),
            .IidW    (IidW)
        ) u_slot (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .load_i    (slot_load[g]),
            .iid_i     (wreq_iid_i),
            .delay_i   (delay_load),
            .ack_i     (released_addr_onehot_i),
            .valid_o   (slot_valid[g]),
            .iid_o     (slot_iid[g]),
            .release_o (slot_release[g]),
            .retire_o  (slot_retire[g])
        );
    end

    always_comb begin
        release_en_o = '0;
        num_retire   = '0;
        iid_busy     = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            if (slot_release[i]) begin
                release_en_o[slot_iid[i]] = 1'b1;
            end
            num_retire = num_retire + OccW'(slot_retire[i]);
            if (slot_valid[i] && (slot_iid[i] == wreq_iid_i)) begin
                iid_busy = 1'b1;
            end
        end
    end

    assign occ_d       = occ_q + OccW'(accept) - num_retire;
    assign occupancy_o = occ_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef SIMMEM_DELAY_STATS_EN
    logic [31:0]     stat_rel_q;
    logic [OccW-1:0] stat_max_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_rel_q <= '0;
            stat_max_q <= '0;
        end else begin
            stat_rel_q <= stat_rel_q + 32'(num_retire);
            if (occ_q > stat_max_q) begin
                stat_max_q <= occ_q;
            end
        end
    end

    assign stat_releases_o = stat_rel_q;
    assign stat_max_occ_o  = stat_max_q;
`endif

    a_iid_unique: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> !iid_busy);
    a_burst_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> (wreq_burst_len_i != 8'd0));
    a_ack_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(released_addr_onehot_i));

endmodule
